// File: rtl/ahb_sram_responder.sv
// AHB-Lite SRAM responder: single-port byte-lane storage, optional wait states.
// Define AHB_SRAM_ERR_EN to enable ERROR responses for oversize/misaligned transfers.
module ahb_sram_responder #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_BYTES_LOG2 = 10,
  parameter int WAIT_STATES    = 0
) (
  input  logic                    hclk,
  input  logic                    hresetn,
  input  logic                    hselx,
  input  logic [ADDR_WIDTH-1:0]   haddr,
  input  logic [1:0]              htrans,
  input  logic                    hwrite,
  input  logic [2:0]              hsize,
  input  logic [2:0]              hburst,
  input  logic [3:0]              hprot,
  input  logic                    hmastlock,
  input  logic [DATA_WIDTH-1:0]   hwdata,
  input  logic [DATA_WIDTH/8-1:0] hwstrb,
  input  logic                    hready,
  output logic                    hreadyout,
  output logic [DATA_WIDTH-1:0]   hrdata,
  output logic [1:0]              hresp
);

  localparam int LANES = DATA_WIDTH / 8;
  localparam int OFS   = $clog2(LANES);
  localparam int IDX_W = MEM_BYTES_LOG2 - OFS;
  localparam int WORDS = 2 ** IDX_W;

  localparam logic [1:0] OKAY  = 2'b00;
  localparam logic [1:0] ERROR = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t           state;
  logic [3:0]       cnt;
  logic             rdy_q;
  logic [1:0]       resp_q;
  logic [IDX_W-1:0] idx_q;
  logic [LANES-1:0] lane_q;
  logic             wr_q;

  logic [DATA_WIDTH-1:0] mem [WORDS];

  logic             accept;
  logic             illegal;
  logic [OFS-1:0]   off;
  logic [LANES-1:0] lane_n;

  logic unused_bits;
  assign unused_bits = ^{hburst, hprot, hmastlock, htrans[0],
                         haddr[ADDR_WIDTH-1:MEM_BYTES_LOG2]};

  assign off    = haddr[OFS-1:0];
  assign accept = hselx & hready & htrans[1] &
                  (state inside {S_IDLE, S_DATA, S_ERR2});

  // A lane is active when it shares the 2^hsize-aligned block of the address;
  // this also aligns down misaligned offsets and widens oversize hsize.
  always_comb begin
    lane_n = '0;
    for (int k = 0; k < LANES; k++)
      lane_n[k] = ((k >> hsize) == (int'(off) >> hsize));
  end

`ifdef AHB_SRAM_ERR_EN
  logic [OFS-1:0] amask;
  assign amask   = OFS'((32'd1 << hsize) - 32'd1);
  assign illegal = (hsize > 3'(OFS)) || (|(off & amask));
`else
  assign illegal = 1'b0;
`endif

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state  <= S_IDLE;
      cnt    <= '0;
      rdy_q  <= 1'b1;
      resp_q <= OKAY;
      idx_q  <= '0;
      lane_q <= '0;
      wr_q   <= 1'b0;
    end else begin
      unique case (state)
        S_WAIT: begin
          if (cnt == 4'd1) begin
            state <= S_DATA;
            cnt   <= '0;
            rdy_q <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_ERR1: begin
          state  <= S_ERR2;
          rdy_q  <= 1'b1;
          resp_q <= ERROR;
        end
        default: begin
          wr_q <= 1'b0;
          if (!accept) begin
            state  <= S_IDLE;
            rdy_q  <= 1'b1;
            resp_q <= OKAY;
          end else if (illegal) begin
            state  <= S_ERR1;
            rdy_q  <= 1'b0;
            resp_q <= ERROR;
          end else begin
            idx_q  <= haddr[MEM_BYTES_LOG2-1:OFS];
            lane_q <= lane_n;
            wr_q   <= hwrite;
            resp_q <= OKAY;
            if (WAIT_STATES > 0) begin
              state <= S_WAIT;
              cnt   <= 4'(WAIT_STATES);
              rdy_q <= 1'b0;
            end else begin
              state <= S_DATA;
              rdy_q <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  // Storage is deliberately not reset; writes land at the edge ending DATA.
  always_ff @(posedge hclk) begin
    if (state == S_DATA && wr_q) begin
      for (int k = 0; k < LANES; k++)
        if (hwstrb[k] && lane_q[k])
          mem[idx_q][k*8 +: 8] <= hwdata[k*8 +: 8];
    end
  end

  // Combinational read path so a read right after a write sees the new bytes.
  always_comb begin
    hrdata = '0;
    if (state == S_DATA && !wr_q) begin
      for (int k = 0; k < LANES; k++)
        if (lane_q[k])
          hrdata[k*8 +: 8] = mem[idx_q][k*8 +: 8];
    end
  end

  assign hreadyout = rdy_q;
  assign hresp     = resp_q;

endmodule

// File: tb/tb_ahb_sram_responder.sv
// Directed bench: one zero-wait and one two-wait instance on a shared bus.
module tb_ahb_sram_responder;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        hselx0;
  logic        hselx1;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic        hmastlock;
  logic [31:0] hwdata;
  logic [3:0]  hwstrb;
  logic        hreadyout0;
  logic        hreadyout1;
  logic [31:0] hrdata0;
  logic [31:0] hrdata1;
  logic [1:0]  hresp0;
  logic [1:0]  hresp1;

  int checks = 0;
  int failures = 0;

  always #5 hclk = ~hclk;

  ahb_sram_responder #(.WAIT_STATES(0)) u_ws0 (
    .hclk(hclk), .hresetn(hresetn), .hselx(hselx0), .haddr(haddr),
    .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
    .hprot(hprot), .hmastlock(hmastlock), .hwdata(hwdata),
    .hwstrb(hwstrb), .hready(hreadyout0), .hreadyout(hreadyout0),
    .hrdata(hrdata0), .hresp(hresp0)
  );

  ahb_sram_responder #(.WAIT_STATES(2)) u_ws2 (
    .hclk(hclk), .hresetn(hresetn), .hselx(hselx1), .haddr(haddr),
    .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
    .hprot(hprot), .hmastlock(hmastlock), .hwdata(hwdata),
    .hwstrb(hwstrb), .hready(hreadyout1), .hreadyout(hreadyout1),
    .hrdata(hrdata1), .hresp(hresp1)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic rdy(input int s);
    return (s == 0) ? hreadyout0 : hreadyout1;
  endfunction

  function automatic logic [1:0] rsp_of(input int s);
    return (s == 0) ? hresp0 : hresp1;
  endfunction

  // Single non-pipelined transfer; returns wait count and data-phase results.
  task automatic xfer(input int s, input logic wr, input logic [31:0] a,
                      input logic [2:0] sz, input logic [31:0] wd,
                      input logic [3:0] st, output int waits,
                      output logic [1:0] rsp_lo, output logic [31:0] rd,
                      output logic [1:0] rsp);
    @(posedge hclk); #1;
    hselx0 = (s == 0);
    hselx1 = (s == 1);
    htrans = 2'b10;
    haddr  = a;
    hwrite = wr;
    hsize  = sz;
    @(posedge hclk); #1;
    hselx0 = 1'b0;
    hselx1 = 1'b0;
    htrans = 2'b00;
    hwdata = wd;
    hwstrb = st;
    waits  = 0;
    rsp_lo = 2'b00;
    @(negedge hclk);
    while (!rdy(s) && waits < 40) begin
      waits++;
      rsp_lo = rsp_of(s);
      @(negedge hclk);
    end
    rd  = (s == 0) ? hrdata0 : hrdata1;
    rsp = rsp_of(s);
  endtask

  int         w;
  logic [1:0] rl;
  logic [31:0] rd;
  logic [1:0] rp;

  initial begin
    hresetn = 1'b0;
    hselx0 = 1'b0; hselx1 = 1'b0;
    haddr = '0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd2;
    hburst = 3'b011; hprot = 4'b0011; hmastlock = 1'b0;
    hwdata = '0; hwstrb = '0;
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    check("rst_rdy0", hreadyout0, 1'b1);
    check("rst_resp0", hresp0, 2'b00);
    check("rst_rdata0", hrdata0, 32'h0);
    check("rst_rdy1", hreadyout1, 1'b1);
    @(posedge hclk); #1;
    hresetn = 1'b1;

    xfer(0, 1'b1, 32'h004, 3'd2, 32'hDEADBEEF, 4'hF, w, rl, rd, rp);
    check("w4_waits", w, 0);
    check("w4_resp", rp, 2'b00);
    check("w4_rdata_zero", rd, 32'h0);
    xfer(0, 1'b0, 32'h004, 3'd2, 32'h0, 4'h0, w, rl, rd, rp);
    check("r4_waits", w, 0);
    check("r4_data", rd, 32'hDEADBEEF);
    check("r4_resp", rp, 2'b00);

    xfer(0, 1'b1, 32'h000, 3'd2, 32'h11223344, 4'hF, w, rl, rd, rp);
    xfer(0, 1'b1, 32'h003, 3'd0, 32'hABFFFFFF, 4'hF, w, rl, rd, rp);
    xfer(0, 1'b0, 32'h000, 3'd2, 32'h0, 4'h0, w, rl, rd, rp);
    check("byte_merge", rd, 32'hAB223344);
    xfer(0, 1'b0, 32'h001, 3'd0, 32'h0, 4'h0, w, rl, rd, rp);
    check("byte_read", rd, 32'h00003300);
    xfer(0, 1'b0, 32'h002, 3'd1, 32'h0, 4'h0, w, rl, rd, rp);
    check("half_read", rd, 32'hAB220000);

    xfer(0, 1'b1, 32'h008, 3'd2, 32'h00000000, 4'hF, w, rl, rd, rp);
    xfer(0, 1'b1, 32'h008, 3'd2, 32'hFFFFFFFF, 4'b0101, w, rl, rd, rp);
    xfer(0, 1'b0, 32'h008, 3'd2, 32'h0, 4'h0, w, rl, rd, rp);
    check("strobe_gate", rd, 32'h00FF00FF);

    xfer(0, 1'b1, 32'h430, 3'd2, 32'h12345678, 4'hF, w, rl, rd, rp);
    xfer(0, 1'b0, 32'h030, 3'd2, 32'h0, 4'h0, w, rl, rd, rp);
    check("wrap", rd, 32'h12345678);

    // Back-to-back write then read of the same word.
    @(posedge hclk); #1;
    hselx0 = 1'b1; htrans = 2'b10; haddr = 32'h020;
    hwrite = 1'b1; hsize = 3'd2;
    @(posedge hclk); #1;
    hwdata = 32'h0000CAFE; hwstrb = 4'hF;
    htrans = 2'b10; haddr = 32'h020; hwrite = 1'b0;
    @(negedge hclk);
    check("b2b_wr_rdy", hreadyout0, 1'b1);
    @(posedge hclk); #1;
    hselx0 = 1'b0; htrans = 2'b00;
    @(negedge hclk);
    check("b2b_rd_rdy", hreadyout0, 1'b1);
    check("b2b_rd_data", hrdata0, 32'h0000CAFE);

    xfer(1, 1'b1, 32'h010, 3'd2, 32'h5A5A0001, 4'hF, w, rl, rd, rp);
    check("ws2_wr_waits", w, 2);
    xfer(1, 1'b0, 32'h010, 3'd2, 32'h0, 4'h0, w, rl, rd, rp);
    check("ws2_rd_waits", w, 2);
    check("ws2_rd_lo_resp", rl, 2'b00);
    check("ws2_rd_data", rd, 32'h5A5A0001);
    check("ws2_rd_resp", rp, 2'b00);

    // IDLE and BUSY with select high must not insert waits.
    @(posedge hclk); #1;
    hselx1 = 1'b1; htrans = 2'b00; haddr = 32'h010;
    @(posedge hclk); #1;
    htrans = 2'b01;
    @(negedge hclk);
    check("idle_rdy", hreadyout1, 1'b1);
    @(posedge hclk); #1;
    hselx1 = 1'b0; htrans = 2'b00;
    @(negedge hclk);
    check("busy_rdy", hreadyout1, 1'b1);

    // Reset asserted mid-wait.
    @(posedge hclk); #1;
    hselx1 = 1'b1; htrans = 2'b10; haddr = 32'h010; hwrite = 1'b0;
    @(posedge hclk); #1;
    hselx1 = 1'b0; htrans = 2'b00;
    @(negedge hclk);
    check("mid_wait_rdy", hreadyout1, 1'b0);
    hresetn = 1'b0;
    #1;
    check("rst_wait_rdy", hreadyout1, 1'b1);
    check("rst_wait_resp", hresp1, 2'b00);
    check("rst_wait_rdata", hrdata1, 32'h0);
    @(posedge hclk); #1;
    hresetn = 1'b1;
    xfer(1, 1'b0, 32'h010, 3'd2, 32'h0, 4'h0, w, rl, rd, rp);
    check("post_rst_ws2", rd, 32'h5A5A0001);
    xfer(0, 1'b0, 32'h004, 3'd2, 32'h0, 4'h0, w, rl, rd, rp);
    check("post_rst_ws0", rd, 32'hDEADBEEF);

    xfer(0, 1'b1, 32'h001, 3'd1, 32'h00005566, 4'hF, w, rl, rd, rp);
`ifdef AHB_SRAM_ERR_EN
    check("err_waits", w, 1);
    check("err1_resp", rl, 2'b01);
    check("err2_resp", rp, 2'b01);
    xfer(0, 1'b0, 32'h000, 3'd2, 32'h0, 4'h0, w, rl, rd, rp);
    check("err_no_write", rd, 32'hAB223344);
`else
    check("mis_waits", w, 0);
    check("mis_resp", rp, 2'b00);
    xfer(0, 1'b0, 32'h000, 3'd2, 32'h0, 4'h0, w, rl, rd, rp);
    check("mis_align_down", rd, 32'hAB225566);
`endif

    repeat (2) @(posedge hclk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
